// File: rtl/regfile_debug_master_if.sv
// Host request/response channel between a debug host and regfile_debug_master.
//   req_*  : host -> controller request (valid/ready), write flag, address, write data
//   rsp_*  : controller -> host response (valid/ready), read data, error flag
// master modport is the host side, slave modport is the controller side.
interface regfile_debug_master_if #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned ADDR_W = 5
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [XLEN-1:0]   req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [XLEN-1:0]   rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/regfile_debug_master.sv
// Debug-side initiator for the register file: executes single host reads/writes
// while the core is halted and runs a hardware sweep that zeroes x1..x(NUM_REGS-1).
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   core_halted    : accepts (requests and clears) only start while high
//   clear_start    : one-cycle pulse starting the clear sweep (wins over a request)
//   host           : request/response channel (slave side)
//   busy           : controller not idle
//   rf_write_en/rf_rd_addr/rf_write_data : register-file write port
//   rf_rs1_addr/rf_rs1_data              : register-file rs1 read port (combinational)
module regfile_debug_master #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned ADDR_W   = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              core_halted,
   input  logic              clear_start,
   regfile_debug_master_if.slave host,
   output logic              busy,
   output logic              rf_write_en,
   output logic [ADDR_W-1:0] rf_rd_addr,
   output logic [XLEN-1:0]   rf_write_data,
   output logic [ADDR_W-1:0] rf_rs1_addr,
   input  logic [XLEN-1:0]   rf_rs1_data
);

   localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);

   typedef enum logic [1:0] {IDLE, EXEC, RESP, CLEAR} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] cnt, cnt_nxt;
   logic              wr_q, wr_nxt;
   logic [ADDR_W-1:0] addr_q, addr_nxt;

   logic              busy_nxt;
   logic              we_nxt;
   logic [ADDR_W-1:0] rd_addr_nxt;
   logic [XLEN-1:0]   wdata_nxt;
   logic [ADDR_W-1:0] rs1_addr_nxt;
   logic              rsp_valid_q, rsp_valid_nxt;
   logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_nxt;
   logic              rsp_err_q, rsp_err_nxt;
   logic              req_ready_c;

   // Accept window; gated by rst_n so it is low while reset is held.
   assign req_ready_c    = rst_n && (state == IDLE) && core_halted && !clear_start;
   assign host.req_ready = req_ready_c;
   assign host.rsp_valid = rsp_valid_q;
   assign host.rsp_rdata = rsp_rdata_q;
   assign host.rsp_err   = rsp_err_q;

   // Next state and next values of all registered outputs.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      wr_nxt        = wr_q;
      addr_nxt      = addr_q;
      we_nxt        = 1'b0;
      rd_addr_nxt   = '0;
      wdata_nxt     = '0;
      rs1_addr_nxt  = '0;
      rsp_valid_nxt = 1'b0;
      rsp_rdata_nxt = '0;
      rsp_err_nxt   = 1'b0;

      unique case (state)
         IDLE: begin
            if (core_halted && clear_start) begin
               state_nxt   = CLEAR;
               cnt_nxt     = FIRST_ADDR;
               we_nxt      = 1'b1;
               rd_addr_nxt = FIRST_ADDR;
            end else if (host.req_valid && req_ready_c) begin
               state_nxt = EXEC;
               wr_nxt    = host.req_write;
               addr_nxt  = host.req_addr;
               // Set up the EXEC-cycle port drive now so it is registered.
               if (host.req_write && (host.req_addr != '0)) begin
                  we_nxt      = 1'b1;
                  rd_addr_nxt = host.req_addr;
                  wdata_nxt   = host.req_wdata;
               end else if (!host.req_write) begin
                  rs1_addr_nxt = host.req_addr;
               end
            end
         end
         EXEC: begin
            state_nxt     = RESP;
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = wr_q && (addr_q == '0);
            rsp_rdata_nxt = (!wr_q && (addr_q != '0)) ? rf_rs1_data : '0;
         end
         RESP: begin
            if (host.rsp_ready) begin
               state_nxt = IDLE;
            end else begin
               rsp_valid_nxt = 1'b1;
               rsp_rdata_nxt = rsp_rdata_q;
               rsp_err_nxt   = rsp_err_q;
            end
         end
         CLEAR: begin
            // Counter stops at the last register; address 0 is never issued.
            if (cnt == LAST_ADDR) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt     = cnt + FIRST_ADDR;
               we_nxt      = 1'b1;
               rd_addr_nxt = cnt + FIRST_ADDR;
            end
         end
         default: state_nxt = IDLE;
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

   // State and registered outputs, all cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         wr_q          <= 1'b0;
         addr_q        <= '0;
         busy          <= 1'b0;
         rf_write_en   <= 1'b0;
         rf_rd_addr    <= '0;
         rf_write_data <= '0;
         rf_rs1_addr   <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         wr_q          <= wr_nxt;
         addr_q        <= addr_nxt;
         busy          <= busy_nxt;
         rf_write_en   <= we_nxt;
         rf_rd_addr    <= rd_addr_nxt;
         rf_write_data <= wdata_nxt;
         rf_rs1_addr   <= rs1_addr_nxt;
         rsp_valid_q   <= rsp_valid_nxt;
         rsp_rdata_q   <= rsp_rdata_nxt;
         rsp_err_q     <= rsp_err_nxt;
      end
   end

endmodule
